stream_demux_1xn: RTL and testbench

STREAM_DEMUX_1XN -- requirements
Module: stream_demux_1xn

---
 rtl/stream_demux_pkg.sv | 12 +
 rtl/stream_demux_1xn_if.sv | 30 +++
 rtl/demux_slot.sv | 50 +++++
 rtl/stream_demux_1xn.sv | 72 +++++++
 tb/tb_stream_demux_1xn.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/stream_demux_pkg.sv
// Shared constants and slot-state encoding for the 1-to-N stream demultiplexer.
package stream_demux_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_SEL_W  = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage : stream_demux_pkg

// File: rtl/stream_demux_1xn_if.sv
// Upstream/downstream handshake bundle of the demultiplexer; slave is the demux side.
interface stream_demux_1xn_if
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int SEL_W  = DEFAULT_SEL_W
) ();

  localparam int N = 2 ** SEL_W;

  logic                in_valid;
  logic                in_ready;
  logic [SEL_W-1:0]    in_sel;
  logic                in_bcast;
  logic [DATA_W-1:0]   in_data;
  logic [N-1:0]        out_valid;
  logic [N-1:0]        out_ready;
  logic [N*DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_sel, in_bcast, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sel, in_bcast, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface : stream_demux_1xn_if

// File: rtl/demux_slot.sv
// One-entry output slot of a single demux channel; a load wins over a drain so
// a simultaneous drain+load keeps the slot full with the new word.
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid,
  output logic [DATA_W-1:0] data_out
);

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Next-state: load has priority, drain clears the word so an empty lane reads zero
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = FULL;
      data_d  = data_in;
    end else if (drain) begin
      state_d = EMPTY;
      data_d  = {DATA_W{1'b0}};
    end else begin
      state_d = state_q;
      data_d  = data_q;
    end
  end

  // Slot state and word registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid    = (state_q == FULL);
  assign data_out = data_q;

endmodule : demux_slot

// File: rtl/stream_demux_1xn.sv
// 1-to-N stream demultiplexer: routes each accepted word to one channel slot or,
// on broadcast, to all of them at once.
module stream_demux_1xn
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int SEL_W  = DEFAULT_SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  stream_demux_1xn_if.slave  bus
);

  localparam int N = 2 ** SEL_W;

  logic [N-1:0]        target_s;
  logic [N-1:0]        slot_free_s;
  logic [N-1:0]        load_s;
  logic [N-1:0]        drain_s;
  logic [N-1:0]        valid_s;
  logic [N*DATA_W-1:0] data_s;
  logic                in_ready_s;
  logic                accept_s;

  // Select decode: one-hot channel, or every channel on broadcast
  always_comb begin
    target_s = {N{1'b0}};
    if (bus.in_bcast) begin
      target_s = {N{1'b1}};
    end else begin
      target_s[bus.in_sel] = 1'b1;
    end
  end

  assign drain_s     = valid_s & bus.out_ready;
  assign slot_free_s = ~valid_s | bus.out_ready;

  // Acceptance: broadcast needs every slot free so it never lands partially
  always_comb begin
    in_ready_s = 1'b0;
    if (rst || !en) begin
      in_ready_s = 1'b0;
    end else if (bus.in_bcast) begin
      in_ready_s = &slot_free_s;
    end else begin
      in_ready_s = slot_free_s[bus.in_sel];
    end
  end

  assign accept_s = bus.in_valid & in_ready_s;
  assign load_s   = target_s & {N{accept_s}};

  for (genvar i = 0; i < N; i++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load_s[i]),
      .drain    (drain_s[i]),
      .data_in  (bus.in_data),
      .valid    (valid_s[i]),
      .data_out (data_s[i*DATA_W +: DATA_W])
    );
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = valid_s;
  assign bus.out_data  = data_s;

endmodule : stream_demux_1xn

// File: tb/tb_stream_demux_1xn.sv
// Bench for stream_demux_1xn: directed vector table, then random traffic against a slot-array model.
module tb_stream_demux_1xn;

  localparam int DW = 8;
  localparam int SW = 3;
  localparam int N  = 8;

  logic clk = 1'b0;
  logic rst;
  logic en;

  always #5 clk = ~clk;

  stream_demux_1xn_if #(.DATA_W(DW), .SEL_W(SW)) bus ();

  stream_demux_1xn #(.DATA_W(DW), .SEL_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // reference: what each channel currently holds
  bit          m_full [N];
  logic [7:0]  m_data [N];

  typedef struct {
    logic       r, e, v;
    logic [2:0] s;
    logic       b;
    logic [7:0] d;
    logic [7:0] ordy;
    logic       exp_rdy;
    logic [7:0] exp_ov;
    logic [2:0] lane;
    logic [7:0] exp_lane;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready(input logic r, input logic e, input logic b,
                                     input logic [2:0] s, input logic [7:0] ordy);
    bit ok;
    if (r || !e) return 1'b0;
    if (b) begin
      ok = 1'b1;
      for (int i = 0; i < N; i++) if (m_full[i] && !ordy[i]) ok = 1'b0;
      return ok;
    end
    return !m_full[s] || ordy[s];
  endfunction

  function automatic logic [7:0] model_valid();
    logic [7:0] v;
    for (int i = 0; i < N; i++) v[i] = m_full[i];
    return v;
  endfunction

  function automatic logic [63:0] model_data();
    logic [63:0] o;
    for (int i = 0; i < N; i++) o[i*8 +: 8] = m_full[i] ? m_data[i] : 8'h00;
    return o;
  endfunction

  // One cycle: drive inputs, check in_ready, clock, update model, check outputs.
  task automatic step(input logic r, input logic e, input logic v, input logic [2:0] s,
                      input logic b, input logic [7:0] d, input logic [7:0] ordy,
                      output logic got_rdy);
    bit mr;
    rst = r; en = e;
    bus.in_valid = v; bus.in_sel = s; bus.in_bcast = b; bus.in_data = d;
    bus.out_ready = ordy;
    #2;
    mr = model_ready(r, e, b, s, ordy);
    got_rdy = bus.in_ready;
    check("in_ready", {63'd0, bus.in_ready}, {63'd0, mr});
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (r) begin
        m_full[i] = 1'b0;
      end else if (v && mr && (b || s == i[2:0])) begin
        m_full[i] = 1'b1;
        m_data[i] = d;
      end else if (m_full[i] && ordy[i]) begin
        m_full[i] = 1'b0;
      end
    end
    #1;
    check("out_valid", {56'd0, bus.out_valid}, {56'd0, model_valid()});
    check("out_data", bus.out_data, model_data());
  endtask

  initial begin
    logic rdy;
    for (int i = 0; i < N; i++) begin m_full[i] = 1'b0; m_data[i] = 8'h00; end
    rst = 1'b1; en = 1'b0;
    bus.in_valid = 1'b0; bus.in_sel = 3'd0; bus.in_bcast = 1'b0;
    bus.in_data = 8'h00; bus.out_ready = 8'hFF;

    //              r     e     v     s     b     d      ordy   rdy   ov     lane  lanev
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, 1'b0, 8'h00, 3'd0, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 8'hA5, 8'hFF, 1'b1, 8'h20, 3'd5, 8'hA5};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 8'h11, 8'hFF, 1'b1, 8'h04, 3'd2, 8'h11};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 8'h22, 8'hFB, 1'b0, 8'h04, 3'd2, 8'h11};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 8'h33, 8'hFB, 1'b1, 8'h0C, 3'd2, 8'h11};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 3'd2, 8'h00};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 8'h3C, 8'hFF, 1'b1, 8'hFF, 3'd7, 8'h3C};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 8'h55, 8'h7F, 1'b0, 8'h80, 3'd7, 8'h3C};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 3'd7, 8'h00};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'h01, 8'hFF, 1'b1, 8'h01, 3'd0, 8'h01};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'h02, 8'hFF, 1'b1, 8'h01, 3'd0, 8'h02};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'h03, 8'hFF, 1'b1, 8'h01, 3'd0, 8'h03};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 3'd0, 8'h00};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 8'h44, 8'hEF, 1'b1, 8'h10, 3'd4, 8'h44};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 8'h45, 8'hEF, 1'b0, 8'h10, 3'd4, 8'h44};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 8'h46, 8'hFF, 1'b0, 8'h00, 3'd4, 8'h00};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 8'h77, 8'h00, 1'b1, 8'h02, 3'd1, 8'h77};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 8'h78, 8'h00, 1'b0, 8'h00, 3'd1, 8'h00};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF, 1'b1, 8'h00, 3'd0, 8'h00};

    @(posedge clk); #1;

    for (int k = 0; k < 19; k++) begin
      step(vecs[k].r, vecs[k].e, vecs[k].v, vecs[k].s, vecs[k].b, vecs[k].d, vecs[k].ordy, rdy);
      check($sformatf("tbl%0d_rdy", k), {63'd0, rdy}, {63'd0, vecs[k].exp_rdy});
      check($sformatf("tbl%0d_ov", k), {56'd0, bus.out_valid}, {56'd0, vecs[k].exp_ov});
      check($sformatf("tbl%0d_lane", k), {56'd0, bus.out_data[vecs[k].lane*8 +: 8]},
            {56'd0, vecs[k].exp_lane});
    end

    // stall slot 6 across a broadcast, then release it and retry
    step(1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 8'hC6, 8'hBF, rdy);
    step(1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 8'h9A, 8'hBF, rdy);
    check("bcast_stall_rdy", {63'd0, rdy}, 64'd0);
    step(1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 8'h9A, 8'hFF, rdy);
    check("bcast_retry_ov", {56'd0, bus.out_valid}, 64'hFF);
    check("bcast_retry_d", bus.out_data, {8{8'h9A}});

    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
           1'($urandom()),
           3'($urandom()),
           ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
           8'($urandom()),
           8'($urandom() | $urandom()),
           rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_stream_demux_1xn
